maze_player_ctrl: RTL and testbench



---
 rtl/maze_player_ctrl.sv | 98 +++++++++
 tb/tb_maze_player_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_player_ctrl.sv
// maze_player_ctrl: turns buttons into validated tile moves with auto-repeat; outputs char_x/char_y, viewport x_coord/y_coord, at_goal and move_count
module maze_player_ctrl #(
  parameter int REPEAT_DELAY = 12_500_000,
  parameter int REPEAT_RATE = 2_500_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          load,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic [4095:0] path_data,
  input  logic [6:0]    maze_width,
  input  logic [6:0]    maze_height,
  input  logic [6:0]    view_cols,
  input  logic [6:0]    view_rows,
  input  logic [6:0]    start_x,
  input  logic [6:0]    start_y,
  input  logic [6:0]    goal_x,
  input  logic [6:0]    goal_y,
  output logic [6:0]    char_x,
  output logic [6:0]    char_y,
  output logic [6:0]    x_coord,
  output logic [6:0]    y_coord,
  output logic          at_goal,
  output logic [15:0]   move_count
);
  localparam logic [1:0] WAIT_REL = 2'd0, IDLE = 2'd1, HOLD = 2'd2;
  localparam logic [2:0] D_NONE = 3'd0, D_UP = 3'd1, D_DOWN = 3'd2, D_LEFT = 3'd3, D_RIGHT = 3'd4;
  logic [1:0] state, state_n;
  logic [2:0] dir, lat, lat_n;
  logic [31:0] cnt, cnt_n;
  logic [7:0] tx, ty;
  logic attempt, legal;
  function automatic logic [6:0] vp(input logic [6:0] c, input logic [6:0] cols, input logic [6:0] size);
    logic signed [8:0] v, m;
    v = $signed({2'b0, c}) - $signed({3'b0, cols[6:1]});
    m = $signed({2'b0, size}) - $signed({2'b0, cols});
    return (size <= cols || v[8]) ? 7'd0 : (v > m) ? m[6:0] : v[6:0];
  endfunction
  always_comb begin
    dir = btn_up ? D_UP : btn_down ? D_DOWN : btn_left ? D_LEFT : btn_right ? D_RIGHT : D_NONE;
    tx = {1'b0, char_x} + (dir == D_RIGHT ? 8'd1 : dir == D_LEFT ? 8'hFF : 8'd0);
    ty = {1'b0, char_y} + (dir == D_DOWN ? 8'd1 : dir == D_UP ? 8'hFF : 8'd0);
    legal = tx < {1'b0, maze_width} && ty < {1'b0, maze_height} && path_data[{ty[5:0], tx[5:0]}] && !at_goal;
    state_n = state;
    lat_n = lat;
    cnt_n = cnt;
    attempt = 1'b0;
    if (!enable || at_goal)
      state_n = WAIT_REL;
    else if (state == WAIT_REL)
      state_n = dir == D_NONE ? IDLE : WAIT_REL;
    else if (dir == D_NONE)
      state_n = IDLE;
    else if (state == IDLE || dir != lat) begin
      attempt = 1'b1;
      state_n = HOLD;
      lat_n = dir;
      cnt_n = 32'(REPEAT_DELAY - 1);
    end else if (cnt == 32'd0) begin
      attempt = 1'b1;
      cnt_n = 32'(REPEAT_RATE - 1);
    end else
      cnt_n = cnt - 32'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_REL;
      lat <= D_NONE;
      cnt <= '0;
      char_x <= '0;
      char_y <= '0;
      x_coord <= '0;
      y_coord <= '0;
      at_goal <= 1'b0;
      move_count <= '0;
    end else begin
      state <= load ? WAIT_REL : state_n;
      lat <= lat_n;
      cnt <= cnt_n;
      at_goal <= char_x == goal_x && char_y == goal_y;
      x_coord <= vp(char_x, view_cols, maze_width);
      y_coord <= vp(char_y, view_rows, maze_height);
      if (load) begin
        char_x <= start_x;
        char_y <= start_y;
        move_count <= '0;
      end else if (attempt && legal) begin
        char_x <= tx[6:0];
        char_y <= ty[6:0];
        move_count <= (&move_count) ? move_count : move_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_maze_player_ctrl.sv
// tb_maze_player_ctrl: randomized and directed checks of maze_player_ctrl against a timing-rule reference model
module tb_maze_player_ctrl;
  localparam int RD = 8, RR = 4;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, load = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [4095:0] path_data = '0;
  logic [6:0] maze_width = 7'd8, maze_height = 7'd6, view_cols = 7'd4, view_rows = 7'd4;
  logic [6:0] start_x = '0, start_y = '0, goal_x = 7'd127, goal_y = 7'd127;
  logic [6:0] char_x, char_y, x_coord, y_coord;
  logic at_goal;
  logic [15:0] move_count;
  int passed = 0, total = 0;
  int m_cx = 0, m_cy = 0, m_xc = 0, m_yc = 0, m_mc = 0, held = 0, t0 = 0, cyc = 0;
  bit m_goal = 0, armed = 0;

  maze_player_ctrl #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .path_data(path_data), .maze_width(maze_width), .maze_height(maze_height),
    .view_cols(view_cols), .view_rows(view_rows), .start_x(start_x), .start_y(start_y),
    .goal_x(goal_x), .goal_y(goal_y), .char_x(char_x), .char_y(char_y),
    .x_coord(x_coord), .y_coord(y_coord), .at_goal(at_goal), .move_count(move_count)
  );

  always #5 clk = ~clk;

  function automatic int vp(int c, int cols, int size);
    int v;
    if (size <= cols) return 0;
    v = c - cols / 2;
    if (v < 0) v = 0;
    if (v > size - cols) v = size - cols;
    return v;
  endfunction

  function automatic logic [44:0] obs();
    return {char_x, char_y, x_coord, y_coord, at_goal, move_count};
  endfunction

  function automatic logic [44:0] expv();
    return {7'(m_cx), 7'(m_cy), 7'(m_xc), 7'(m_yc), m_goal, 16'(m_mc)};
  endfunction

  task automatic model_step();
    int d, nx, ny, el, ncx, ncy, nmc, nxc, nyc;
    bit ng, att;
    d = btn_up ? 1 : btn_down ? 2 : btn_left ? 3 : btn_right ? 4 : 0;
    cyc++;
    if (reset) begin
      m_cx = 0; m_cy = 0; m_xc = 0; m_yc = 0; m_mc = 0; m_goal = 0; armed = 0; held = 0;
      return;
    end
    ng = (m_cx == int'(goal_x) && m_cy == int'(goal_y));
    nxc = vp(m_cx, int'(view_cols), int'(maze_width));
    nyc = vp(m_cy, int'(view_rows), int'(maze_height));
    att = 0; ncx = m_cx; ncy = m_cy; nmc = m_mc;
    if (load) begin
      ncx = int'(start_x); ncy = int'(start_y); nmc = 0; armed = 0; held = 0;
    end else if (!enable || m_goal) begin
      armed = 0; held = 0;
    end else if (!armed)
      armed = (d == 0);
    else if (d == 0)
      held = 0;
    else if (d != held) begin
      att = 1; held = d; t0 = cyc;
    end else begin
      el = cyc - t0;
      att = (el == RD) || (el > RD && (el - RD) % RR == 0);
    end
    if (att) begin
      nx = m_cx + (d == 4 ? 1 : d == 3 ? -1 : 0);
      ny = m_cy + (d == 2 ? 1 : d == 1 ? -1 : 0);
      if (nx >= 0 && nx < int'(maze_width) && ny >= 0 && ny < int'(maze_height) && path_data[nx + 64 * ny] && !m_goal) begin
        ncx = nx; ncy = ny;
        if (nmc < 65535) nmc++;
      end
    end
    m_cx = ncx; m_cy = ncy; m_mc = nmc; m_goal = ng; m_xc = nxc; m_yc = nyc;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(bit u, bit d, bit l, bit r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
  endtask

  task automatic do_load(int sx, int sy);
    set_btn(0, 0, 0, 0);
    start_x = 7'(sx); start_y = 7'(sy); load = 1'b1;
    tick();
    load = 1'b0;
    tick();
  endtask

  task automatic cfg_default();
    maze_width = 7'd8; maze_height = 7'd6; view_cols = 7'd4; view_rows = 7'd4;
    goal_x = 7'd127; goal_y = 7'd127; enable = 1'b1; path_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++; if (obs() !== 45'd0) $display("FAIL reset got %h exp 0", obs()); else passed++;
    reset = 1'b0;
    tick();
    total++; if (obs() !== expv()) $display("FAIL reset_model got %h exp %h", obs(), expv()); else passed++;
  endtask

  task automatic test_open_move();
    cfg_default();
    path_data[1 + 64] = 1'b1; path_data[2 + 64] = 1'b1;
    do_load(1, 1);
    set_btn(0, 0, 0, 1);
    tick();
    total++; if (char_x !== 7'd2 || move_count !== 16'd1) $display("FAIL open_move got x=%0d cnt=%0d exp x=2 cnt=1", char_x, move_count); else passed++;
    set_btn(0, 0, 0, 0);
    tick();
    total++; if (x_coord !== 7'd0) $display("FAIL open_xcoord got %0d exp 0", x_coord); else passed++;
    total++; if (obs() !== expv()) $display("FAIL open_model got %h exp %h", obs(), expv()); else passed++;
  endtask

  task automatic test_blocked();
    cfg_default();
    path_data[1 + 64] = 1'b1; path_data[64] = 1'b1;
    do_load(1, 1);
    set_btn(0, 0, 0, 1);
    tick();
    total++; if (char_x !== 7'd1 || char_y !== 7'd1 || move_count !== 16'd0) $display("FAIL wall got (%0d,%0d) cnt=%0d exp (1,1) cnt=0", char_x, char_y, move_count); else passed++;
    do_load(0, 1);
    set_btn(0, 0, 1, 0);
    tick();
    set_btn(0, 0, 0, 0);
    tick();
    total++; if (char_x !== 7'd0 || move_count !== 16'd0) $display("FAIL edge got x=%0d cnt=%0d exp x=0 cnt=0", char_x, move_count); else passed++;
  endtask

  task automatic test_autorepeat();
    cfg_default();
    for (int x = 0; x < 8; x++) path_data[x + 64] = 1'b1;
    do_load(0, 1);
    set_btn(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (obs() !== expv()) $display("FAIL repeat_c%0d got %h exp %h", i, obs(), expv()); else passed++;
    end
    total++; if (char_x !== 7'd4) $display("FAIL repeat_final got x=%0d exp 4", char_x); else passed++;
    set_btn(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_priority();
    cfg_default();
    path_data[1 + 64] = 1'b1; path_data[1] = 1'b1; path_data[2 + 64] = 1'b1; path_data[2] = 1'b1;
    do_load(1, 1);
    set_btn(1, 0, 0, 1);
    tick();
    total++; if (char_x !== 7'd1 || char_y !== 7'd0) $display("FAIL prio_up got (%0d,%0d) exp (1,0)", char_x, char_y); else passed++;
    set_btn(0, 0, 0, 1);
    tick();
    total++; if (char_x !== 7'd2 || char_y !== 7'd0) $display("FAIL prio_right got (%0d,%0d) exp (2,0)", char_x, char_y); else passed++;
    set_btn(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_goal();
    cfg_default();
    for (int x = 0; x < 8; x++) path_data[x + 64] = 1'b1;
    goal_x = 7'd3; goal_y = 7'd1;
    do_load(0, 1);
    for (int i = 0; i < 3; i++) begin
      set_btn(0, 0, 0, 1); tick();
      if (i < 2) begin set_btn(0, 0, 0, 0); tick(); end
    end
    total++; if (char_x !== 7'd3 || at_goal !== 1'b0) $display("FAIL goal_reach got x=%0d g=%0b exp x=3 g=0", char_x, at_goal); else passed++;
    set_btn(0, 0, 0, 0); tick();
    total++; if (at_goal !== 1'b1) $display("FAIL goal_flag got %0b exp 1", at_goal); else passed++;
    set_btn(0, 0, 0, 1); tick(); tick();
    total++; if (char_x !== 7'd3 || move_count !== 16'd3) $display("FAIL goal_ignore got x=%0d cnt=%0d exp x=3 cnt=3", char_x, move_count); else passed++;
    set_btn(0, 0, 0, 0); load = 1'b1; tick(); load = 1'b0;
    total++; if (char_x !== 7'd0 || move_count !== 16'd0) $display("FAIL goal_load got x=%0d cnt=%0d exp x=0 cnt=0", char_x, move_count); else passed++;
    tick();
    total++; if (at_goal !== 1'b0) $display("FAIL goal_clear got %0b exp 0", at_goal); else passed++;
    goal_x = 7'd127; goal_y = 7'd127;
  endtask

  task automatic test_viewport_reset();
    cfg_default();
    path_data = '1;
    do_load(7, 5);
    total++; if (x_coord !== 7'd4 || y_coord !== 7'd2) $display("FAIL vp_clamp_hi got (%0d,%0d) exp (4,2)", x_coord, y_coord); else passed++;
    do_load(1, 1);
    total++; if (x_coord !== 7'd0 || y_coord !== 7'd0) $display("FAIL vp_clamp_lo got (%0d,%0d) exp (0,0)", x_coord, y_coord); else passed++;
    set_btn(0, 0, 0, 1);
    tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (obs() !== 45'd0) $display("FAIL hold_reset got %h exp 0", obs()); else passed++;
    for (int i = 0; i < 12; i++) tick();
    total++; if (char_x !== 7'd0 || move_count !== 16'd0) $display("FAIL reset_held got x=%0d cnt=%0d exp 0", char_x, move_count); else passed++;
    set_btn(0, 0, 0, 0); tick();
    set_btn(0, 0, 0, 1); tick();
    total++; if (char_x !== 7'd1 || obs() !== expv()) $display("FAIL reset_repress got %h exp %h", obs(), expv()); else passed++;
    set_btn(0, 0, 0, 0); tick();
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 4; seg++) begin
      maze_width = 7'($urandom_range(1, 10)); maze_height = 7'($urandom_range(1, 8));
      view_cols = 7'($urandom_range(1, 10)); view_rows = 7'($urandom_range(1, 8));
      path_data = '0;
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++) path_data[x + 64 * y] = ($urandom_range(0, 9) < 7);
      goal_x = 7'($urandom_range(0, int'(maze_width) - 1)); goal_y = 7'($urandom_range(0, int'(maze_height) - 1));
      do_load($urandom_range(0, int'(maze_width) - 1), $urandom_range(0, int'(maze_height) - 1));
      hold = 0;
      for (int i = 0; i < 200; i++) begin
        if (hold == 0) begin
          set_btn($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
          hold = $urandom_range(1, 14);
        end
        hold--;
        enable = ($urandom_range(0, 19) != 0);
        load = ($urandom_range(0, 29) == 0);
        reset = ($urandom_range(0, 199) == 0);
        if (load) begin start_x = 7'($urandom_range(0, int'(maze_width) - 1)); start_y = 7'($urandom_range(0, int'(maze_height) - 1)); end
        tick();
        total++; if (obs() !== expv()) $display("FAIL random_s%0d_c%0d got %h exp %h", seg, i, obs(), expv()); else passed++;
      end
      load = 1'b0; reset = 1'b0; enable = 1'b1;
    end
    set_btn(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_open_move();
    test_blocked();
    test_autorepeat();
    test_priority();
    test_goal();
    test_viewport_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
